// File: rtl/tt_um_mux_rr_arbiter.sv
// tt_um_mux_rr_arbiter: four-way round-robin arbiter that shares a 2-bit data mux.
// Ownership is fair and bounded: a contested owner holds the grant for MAX_HOLD cycles.
// Every hand-off is separated by GAP_CYCLES cycles with grant low.
//
// Ports:
//   clk     - single clock, rising edge
//   rst_n   - synchronous active-low reset
//   ena     - unused (tile always powered)
//   ui_in   - [3:0] level-sensitive requests, [7:4] unused
//   uio_in  - four 2-bit data lanes, lane k = uio_in[2k+1:2k]
//   uio_out - constant 0
//   uio_oe  - constant 0 (all uio pins are inputs)
//   uo_out  - [3:0] one-hot grant, [4] busy, [6:5] owner data, [7] preempt pulse
module tt_um_mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD   = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam int unsigned GapW  = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             preempt_q, preempt_d;

  logic [3:0] req;
  logic       pick_valid;
  logic [1:0] pick_idx;
  logic [1:0] scan_idx;
  logic [1:0] owner_idx;
  logic       busy;
  logic [1:0] data;
  logic       unused;

  assign req    = ui_in[3:0];
  assign unused = ^{ena, ui_in[7:4]};

  // Scan from the farthest offset down to ptr so the nearest requester wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    scan_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      scan_idx = ptr_q + 2'(i);
      if (req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    preempt_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = 4'b0001 << pick_idx;
          hold_d  = HoldW'(1);
          ptr_d   = pick_idx + 2'd1;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // Release takes precedence over expiry, so a same-edge drop never flags preempt.
        if ((req & grant_q) == 4'b0000) begin
          grant_d = 4'b0000;
          gap_d   = GapW'(1);
          state_d = StGap;
        end else if (hold_q == HoldW'(MAX_HOLD) && |(req & ~grant_q)) begin
          grant_d   = 4'b0000;
          gap_d     = GapW'(1);
          preempt_d = 1'b1;
          state_d   = StGap;
        end else if (hold_q != HoldW'(MAX_HOLD)) begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapW'(GAP_CYCLES)) begin
          if (pick_valid) begin
            grant_d = 4'b0001 << pick_idx;
            hold_d  = HoldW'(1);
            ptr_d   = pick_idx + 2'd1;
            state_d = StGrant;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: begin
        grant_d = 4'b0000;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      grant_q   <= 4'b0000;
      ptr_q     <= 2'd0;
      hold_q    <= '0;
      gap_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      preempt_q <= preempt_d;
    end
  end

  always_comb begin
    owner_idx = 2'd0;
    case (grant_q)
      4'b0010: owner_idx = 2'd1;
      4'b0100: owner_idx = 2'd2;
      4'b1000: owner_idx = 2'd3;
      default: owner_idx = 2'd0;
    endcase
  end

  assign busy = |grant_q;

  always_comb begin
    data = 2'b00;
    if (busy) begin
      unique case (owner_idx)
        2'd0: data = uio_in[1:0];
        2'd1: data = uio_in[3:2];
        2'd2: data = uio_in[5:4];
        2'd3: data = uio_in[7:6];
        default: data = 2'b00;
      endcase
    end
  end

  assign uo_out  = {preempt_q, data, busy, grant_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_mux_rr_arbiter.sv
// Directed bench for tt_um_mux_rr_arbiter with hand-computed uo_out values.
// uo_out = {preempt, data[1:0], busy, grant[3:0]}.
module tb_tt_um_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  int n_cmp = 0;
  int n_err = 0;

  tt_um_mux_rr_arbiter #(
    .MAX_HOLD  (8),
    .GAP_CYCLES(1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .uo_out (uo_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle; inputs are changed only at this point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] granted(input int k, input logic [1:0] d);
    logic [3:0] g;
    g = 4'b0001 << k;
    return {1'b0, d, 1'b1, g};
  endfunction

  initial begin
    int seq[5];
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h0F;
    uio_in = 8'h00;

    // 1) reset with all requests high, then single request from owner 0
    step();
    step();
    check_eq("reset_out", uo_out, 8'h00);
    check_eq("uio_out", uio_out, 8'h00);
    check_eq("uio_oe", uio_oe, 8'h00);
    rst_n = 1'b1;
    ui_in = 8'h01;
    step();
    check_eq("first_grant", uo_out, 8'h11);

    // 2) all requesting: 0,1,2,3,0 each for 8 cycles, preempt gap between
    do_reset();
    ui_in = 8'h0F;
    seq = '{0, 1, 2, 3, 0};
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        check_eq($sformatf("rr_own%0d_c%0d", seq[r], c), uo_out, granted(seq[r], 2'b00));
      end
      step();
      check_eq($sformatf("rr_gap%0d", r), uo_out, 8'h80);
    end

    // 3) lone requester keeps the grant indefinitely, then releases
    do_reset();
    ui_in = 8'h04;
    for (int c = 0; c < 20; c++) begin
      step();
      check_eq($sformatf("lone_c%0d", c), uo_out, 8'h14);
    end
    ui_in = 8'h00;
    step();
    check_eq("lone_gap", uo_out, 8'h00);
    step();
    check_eq("lone_idle", uo_out, 8'h00);
    ui_in = 8'h04;
    step();
    check_eq("idle_regrant", uo_out, 8'h14);

    // 4) data steering: lanes of 8'hB4 are {10,11,01,00}
    uio_in = 8'hB4;
    #1;
    check_eq("data_lane2", uo_out, 8'h74);
    ui_in = 8'h02;
    step();
    check_eq("data_gap", uo_out, 8'h00);
    step();
    check_eq("data_lane1", uo_out, 8'h32);
    ui_in = 8'h00;
    step();
    check_eq("data_idle", uo_out, 8'h00);
    uio_in = 8'h00;

    // 5) owners 1 and 3 alternate across the ptr wrap, then mid-grant reset
    do_reset();
    ui_in = 8'h0A;
    for (int c = 0; c < 8; c++) begin
      step();
      check_eq($sformatf("wrap_o1_c%0d", c), uo_out, 8'h12);
    end
    step();
    check_eq("wrap_gap_a", uo_out, 8'h80);
    for (int c = 0; c < 8; c++) begin
      step();
      check_eq($sformatf("wrap_o3_c%0d", c), uo_out, 8'h18);
    end
    step();
    check_eq("wrap_gap_b", uo_out, 8'h80);
    step();
    check_eq("wrap_o1_again", uo_out, 8'h12);
    step();
    rst_n = 1'b0;
    step();
    check_eq("midgrant_reset", uo_out, 8'h00);
    rst_n = 1'b1;
    ui_in = 8'h00;
    step();
    check_eq("post_reset_idle", uo_out, 8'h00);

    // 6) owner 0 saturated, drops req while req[1] waits: release, not preempt
    do_reset();
    ui_in = 8'h01;
    for (int c = 0; c < 10; c++) step();
    check_eq("sat_owner0", uo_out, 8'h11);
    ui_in = 8'h02;
    step();
    check_eq("release_no_preempt", uo_out, 8'h00);
    step();
    check_eq("after_release_o1", uo_out, 8'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
